// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-ported unified memory between the instruction
// fetch port (I, read-only) and the data access port (D, read/write).
// D wins ties; a starvation counter forces an I grant after STARVE_LIMIT
// consecutive D grants while I is waiting. One transaction is in flight at a
// time, completed by the memory's mem_ready handshake.
module mem_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  // instruction fetch port
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ready,
  output logic [WORD_SIZE-1:0] i_data,
  // data access port
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ready,
  output logic [WORD_SIZE-1:0] d_rdata,
  // memory side
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  // status
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY_I,
    ST_BUSY_D
  } state_t;

  state_t               state_q,      state_d;
  logic [CNT_W-1:0]     starve_cnt_q, starve_cnt_d;
  logic                 mem_req_q,    mem_req_d;
  logic                 mem_we_q,     mem_we_d;
  logic [WORD_SIZE-1:0] mem_addr_q,   mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q,  mem_wdata_d;
  logic                 i_ready_q,    i_ready_d;
  logic                 d_ready_q,    d_ready_d;
  logic [WORD_SIZE-1:0] i_data_q,     i_data_d;
  logic [WORD_SIZE-1:0] d_rdata_q,    d_rdata_d;
  logic                 busy_q,       busy_d;

  logic                 i_elig;
  logic                 d_elig;
  logic                 starve_hit;

  // Next-state, arbitration and completion logic.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_data_d     = i_data_q;
    d_rdata_d    = d_rdata_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;

    // A port whose ready is pulsing still has req high; it must not be
    // re-granted until the cycle after the pulse.
    i_elig     = i_req & ~i_ready_q;
    d_elig     = d_req & ~d_ready_q;
    starve_hit = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    unique case (state_q)
      ST_IDLE: begin
        if (d_elig && !(i_elig && starve_hit)) begin
          state_d     = ST_BUSY_D;
          mem_addr_d  = d_addr;
          mem_we_d    = d_we;
          mem_wdata_d = d_wdata;
          // Counts D grants that happen while I is asking, including the
          // I ready-pulse cycle where I itself is not eligible.
          if (i_req) begin
            if (!starve_hit) begin
              starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
          end else begin
            starve_cnt_d = '0;
          end
        end else if (i_elig) begin
          state_d      = ST_BUSY_I;
          mem_addr_d   = i_addr;
          mem_we_d     = 1'b0;
          starve_cnt_d = '0;
        end
      end

      ST_BUSY_I: begin
        if (mem_ready) begin
          state_d   = ST_IDLE;
          i_data_d  = mem_rdata;
          i_ready_d = 1'b1;
          mem_we_d  = 1'b0;
        end
      end

      ST_BUSY_D: begin
        if (mem_ready) begin
          state_d   = ST_IDLE;
          d_rdata_d = mem_rdata;
          d_ready_d = 1'b1;
          mem_we_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_req_d = (state_d != ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
  end

  // State and registered outputs; synchronous active-low reset abandons any
  // in-flight access.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_data_q     <= '0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      i_data_q     <= i_data_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_data    = i_data_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table-driven single-transaction vectors,
// hand-written multi-cycle sequences, and a randomized run against a
// transaction-level reference model.
module tb_mem_arbiter;

  localparam int W  = 16;
  localparam int SL = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_req;
  logic [W-1:0] i_addr;
  logic         i_ready;
  logic [W-1:0] i_data;
  logic         d_req;
  logic         d_we;
  logic [W-1:0] d_addr;
  logic [W-1:0] d_wdata;
  logic         d_ready;
  logic [W-1:0] d_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  logic         mem_ready;
  logic         busy;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_SIZE(W), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clr_inputs();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},   mem_req,   0);
    chk({tag, "_mem_we"},    mem_we,    0);
    chk({tag, "_mem_addr"},  mem_addr,  0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_i_ready"},   i_ready,   0);
    chk({tag, "_d_ready"},   d_ready,   0);
    chk({tag, "_i_data"},    i_data,    0);
    chk({tag, "_d_rdata"},   d_rdata,   0);
    chk({tag, "_busy"},      busy,      0);
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic         ireq;
    logic         dreq;
    logic         dwe;
    logic [W-1:0] iaddr;
    logic [W-1:0] daddr;
    logic [W-1:0] dwdata;
    int           lat;        // cycles mem_ready is withheld after the grant
    logic [W-1:0] rdata;
    logic         idle_rdy;   // mem_ready asserted while still in IDLE
    int           exp_port;   // 0 none, 1 I, 2 D
    logic [W-1:0] exp_addr;
    logic         exp_we;
    logic [W-1:0] exp_wdata;
  } vec_t;

  vec_t vecs[6];

  // ---------------- reference model ----------------
  // Tracks which port owns the memory, who completed last cycle, the
  // starvation run length and the values each output must carry.
  int           m_owner;      // 0 none, 1 I, 2 D
  bit           m_ir, m_dr;
  int           m_run;
  logic [W-1:0] m_addr, m_wdata, m_idata, m_drdata;
  bit           m_we;
  bit           m_was_reset;

  task automatic model_reset();
    m_owner = 0; m_ir = 0; m_dr = 0; m_run = 0;
    m_addr = '0; m_wdata = '0; m_idata = '0; m_drdata = '0; m_we = 0;
  endtask

  task automatic model_step();
    bit ie, de, nir, ndr;
    m_was_reset = !reset_n;
    if (!reset_n) begin
      model_reset();
    end else begin
      nir = 0; ndr = 0;
      if (m_owner == 0) begin
        ie = i_req && !m_ir;
        de = d_req && !m_dr;
        if (de && !(ie && m_run == SL)) begin
          m_owner = 2; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
          m_run = i_req ? ((m_run < SL) ? m_run + 1 : SL) : 0;
        end else if (ie) begin
          m_owner = 1; m_addr = i_addr; m_we = 0; m_run = 0;
        end
      end else if (mem_ready) begin
        if (m_owner == 1) begin m_idata = mem_rdata; nir = 1; end
        else begin m_drdata = mem_rdata; ndr = 1; end
        m_owner = 0;
      end
      m_ir = nir; m_dr = ndr;
    end
  endtask

  task automatic model_check();
    chk("rnd_mem_req", mem_req, m_owner != 0);
    chk("rnd_busy",    busy,    m_owner != 0);
    chk("rnd_i_ready", i_ready, m_ir);
    chk("rnd_d_ready", d_ready, m_dr);
    chk("rnd_i_data",  i_data,  m_idata);
    chk("rnd_d_rdata", d_rdata, m_drdata);
    if (m_owner != 0 || m_was_reset) begin
      chk("rnd_mem_addr", mem_addr, m_addr);
      chk("rnd_mem_we",   mem_we,   m_we);
    end
    if (m_owner == 2 || m_was_reset) chk("rnd_mem_wdata", mem_wdata, m_wdata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 0, 16'hA5A5, 1'b0, 1, 16'h0010, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 16'h0020, 16'h0040, 16'h1234, 0, 16'h0000, 1'b1, 2, 16'h0040, 1'b1, 16'h1234};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0100, 16'h0000, 2, 16'hBEEF, 1'b0, 2, 16'h0100, 1'b0, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 16'h0123, 16'h0456, 16'h0789, 0, 16'h0000, 1'b1, 0, 16'h0000, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 16'h0002, 16'h7FFE, 16'hCAFE, 1, 16'h0F0F, 1'b0, 2, 16'h7FFE, 1'b0, 16'hCAFE};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'hFFFF, 5, 16'h3C3C, 1'b0, 2, 16'hFFFF, 1'b1, 16'hFFFF};

    // reset state, with requests and mem_ready active during reset
    reset_n = 1'b0;
    clr_inputs();
    i_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1;
    tick();
    tick();
    chk_all_zero("reset");

    // table vectors, each from a fresh reset
    for (int v = 0; v < 6; v++) begin
      do_reset();
      i_req = vecs[v].ireq; i_addr = vecs[v].iaddr;
      d_req = vecs[v].dreq; d_we = vecs[v].dwe;
      d_addr = vecs[v].daddr; d_wdata = vecs[v].dwdata;
      mem_ready = vecs[v].idle_rdy; mem_rdata = 16'hDEAD;
      tick();
      mem_ready = 1'b0;
      chk("vec_mem_req", mem_req, vecs[v].exp_port != 0);
      chk("vec_busy",    busy,    vecs[v].exp_port != 0);
      if (vecs[v].exp_port == 0) begin
        chk("vec_idle_i_ready", i_ready, 0);
        chk("vec_idle_d_ready", d_ready, 0);
      end else begin
        chk("vec_mem_addr", mem_addr, vecs[v].exp_addr);
        chk("vec_mem_we",   mem_we,   vecs[v].exp_we);
        if (vecs[v].exp_port == 2) chk("vec_mem_wdata", mem_wdata, vecs[v].exp_wdata);
        for (int c = 0; c < vecs[v].lat; c++) begin
          tick();
          chk("vec_wait_mem_req", mem_req, 1);
          chk("vec_wait_ready", {i_ready, d_ready}, 0);
        end
        mem_ready = 1'b1; mem_rdata = vecs[v].rdata;
        tick();
        mem_ready = 1'b0;
        chk("vec_i_ready", i_ready, vecs[v].exp_port == 1);
        chk("vec_d_ready", d_ready, vecs[v].exp_port == 2);
        chk("vec_done_mem_req", mem_req, 0);
        if (vecs[v].exp_port == 1) chk("vec_i_data", i_data, vecs[v].rdata);
        if (vecs[v].exp_port == 2 && !vecs[v].exp_we) chk("vec_d_rdata", d_rdata, vecs[v].rdata);
        i_req = 1'b0; d_req = 1'b0;
        tick();
        chk("vec_pulse_end", {i_ready, d_ready}, 0);
      end
    end

    // D first, then I granted during the d_ready pulse cycle
    do_reset();
    i_req = 1'b1; i_addr = 16'h0020;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234;
    tick();
    chk("prio_mem_we", mem_we, 1);
    chk("prio_mem_addr", mem_addr, 16'h0040);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; d_req = 1'b0;
    chk("prio_d_ready", d_ready, 1);
    tick();
    chk("prio_i_grant_req", mem_req, 1);
    chk("prio_i_grant_addr", mem_addr, 16'h0020);
    chk("prio_i_grant_we", mem_we, 0);
    chk("prio_d_ready_gone", d_ready, 0);
    mem_ready = 1'b1; mem_rdata = 16'h5555;
    tick();
    mem_ready = 1'b0; i_req = 1'b0;
    chk("prio_i_ready", i_ready, 1);
    chk("prio_i_data", i_data, 16'h5555);
    tick();

    // starvation guard: I waits through three D grants, then must win;
    // the second round shows the run length restarted from zero
    do_reset();
    i_addr = 16'h0300; d_we = 1'b0; d_addr = 16'h0400;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        i_req = 1'b1; d_req = 1'b1;
        tick();
        chk("starve_mem_req", mem_req, 1);
        chk("starve_grant_addr", mem_addr, (k == 3) ? 16'h0300 : 16'h0400);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("starve_i_ready", i_ready, k == 3);
        chk("starve_d_ready", d_ready, k != 3);
        i_req = 1'b0; d_req = 1'b0;
        tick();
        chk("starve_idle", mem_req, 0);
      end
    end

    // variable latency with requester inputs changing during the wait
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0ABC; d_wdata = 16'h5A5A;
    tick();
    for (int c = 0; c < 5; c++) begin
      d_addr = d_addr ^ 16'hFFFF; d_wdata = d_wdata ^ 16'hFFFF;
      chk("lat_mem_req", mem_req, 1);
      chk("lat_mem_addr", mem_addr, 16'h0ABC);
      chk("lat_mem_wdata", mem_wdata, 16'h5A5A);
      chk("lat_mem_we", mem_we, 1);
      chk("lat_d_ready", d_ready, 0);
      tick();
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; d_req = 1'b0;
    chk("lat_d_ready_pulse", d_ready, 1);
    tick();
    chk("lat_d_ready_single", d_ready, 0);

    // reset while BUSY_I, then a late mem_ready
    do_reset();
    i_req = 1'b1; i_addr = 16'h0777;
    tick();
    chk("rst_busy_i", mem_req, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; i_req = 1'b0;
    mem_ready = 1'b1; mem_rdata = 16'h9999;
    chk_all_zero("rst_mid");
    tick();
    mem_ready = 1'b0;
    chk("rst_late_i_ready", i_ready, 0);
    chk("rst_late_mem_req", mem_req, 0);
    chk("rst_late_i_data", i_data, 0);
    tick();
    chk("rst_late_i_ready2", i_ready, 0);

    // no re-grant of I during its own ready pulse
    do_reset();
    i_req = 1'b1; i_addr = 16'h0011;
    tick();
    mem_ready = 1'b1; mem_rdata = 16'h1111;
    tick();
    mem_ready = 1'b0;
    chk("regrant_i_ready", i_ready, 1);
    i_addr = 16'h0012;
    tick();
    chk("regrant_none_req", mem_req, 0);
    chk("regrant_none_busy", busy, 0);
    chk("regrant_pulse_end", i_ready, 0);
    tick();
    chk("regrant_next_req", mem_req, 1);
    chk("regrant_next_addr", mem_addr, 16'h0012);
    i_req = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();

    // randomized run against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      if (!i_req) begin
        if ($urandom_range(0, 2) == 0) begin
          i_req = 1'b1; i_addr = W'($urandom);
        end
      end else if (m_ir) begin
        if ($urandom_range(0, 1) == 0) i_addr = W'($urandom);
        else i_req = 1'b0;
      end else if (m_owner != 1 && $urandom_range(0, 7) == 0) begin
        i_req = 1'b0;
      end
      if (!d_req) begin
        if ($urandom_range(0, 2) == 0) begin
          d_req = 1'b1; d_we = 1'($urandom);
          d_addr = W'($urandom); d_wdata = W'($urandom);
        end
      end else if (m_dr) begin
        if ($urandom_range(0, 1) == 0) begin
          d_we = 1'($urandom); d_addr = W'($urandom); d_wdata = W'($urandom);
        end else begin
          d_req = 1'b0;
        end
      end else if (m_owner != 2 && $urandom_range(0, 7) == 0) begin
        d_req = 1'b0;
      end
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = W'($urandom);
      model_step();
      tick();
      model_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
